// File: rtl/sig_pkt_width_fifo.sv
// sig_pkt_width_fifo: width-converting packet FIFO with commit/abort, wr side WR_DATA_WIDTH words, rd side RD_DATA_WIDTH units
module sig_pkt_width_fifo #(
  parameter int WR_DATA_WIDTH    = 32,
  parameter int RD_DATA_WIDTH    = 8,
  parameter int DEPTH_WIDTH      = 12,
  parameter bit MSB_FIRST        = 1,
  parameter bit PKT_MODE         = 1,
  parameter int ALMOST_FULL_NUM  = 128,
  parameter int ALMOST_EMPTY_NUM = 5,
  parameter int FRAME_CNT_WIDTH  = 8,
  localparam int RATIO = WR_DATA_WIDTH / RD_DATA_WIDTH,
  localparam int LR    = $clog2(RATIO)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WR_DATA_WIDTH-1:0]   wr_data,
  input  logic                       wr_eop,
  input  logic [LR:0]                wr_eop_units,
  input  logic                       wr_abort,
  output logic                       wr_full,
  output logic                       almost_full,
  output logic [DEPTH_WIDTH:0]       wr_water_level,
  output logic                       wr_overflow,
  input  logic                       rd_en,
  output logic [RD_DATA_WIDTH-1:0]   rd_data,
  output logic                       rd_eop,
  output logic                       rd_empty,
  output logic                       almost_empty,
  output logic [DEPTH_WIDTH:0]       rd_water_level,
  output logic [FRAME_CNT_WIDTH-1:0] rd_frames,
  output logic                       rd_underflow
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_TH = (DEPTH_WIDTH+1)'(DEPTH - RATIO);
  localparam logic [DEPTH_WIDTH:0] AF_TH   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_TH   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
  localparam logic [LR:0]          RATIO_N = (LR+1)'(RATIO);
  logic [RD_DATA_WIDTH:0] mem [DEPTH];
  logic [DEPTH_WIDTH:0] wptr, cptr, rptr, wptr_n;
  logic                 drop_pend, abort, ovf, wr_ok, rd_ok, rewind, commit, fr_inc, fr_dec;
  logic [LR:0]          n;
  logic [RD_DATA_WIDTH:0] rd_unit;
  assign wr_water_level = wptr - rptr;
  assign rd_water_level = cptr - rptr;
  assign rd_empty       = cptr == rptr;
  assign wr_full        = wr_water_level > FULL_TH;
  assign almost_full    = wr_water_level >= AF_TH;
  assign almost_empty   = rd_water_level <= AE_TH;
  assign rd_unit        = mem[rptr[DEPTH_WIDTH-1:0]];
  always_comb begin
    abort  = PKT_MODE && wr_abort;
    ovf    = wr_en && wr_full && !abort;
    wr_ok  = wr_en && !wr_full && !drop_pend && !abort;
    // a dropped frame ends at its eop word, which rewinds instead of committing
    rewind = abort || (PKT_MODE && wr_en && wr_eop && (drop_pend || wr_full));
    n      = (wr_eop && wr_eop_units != '0) ? wr_eop_units : RATIO_N;
    wptr_n = wptr + (DEPTH_WIDTH+1)'(n);
    commit = wr_ok && (wr_eop || !PKT_MODE);
    rd_ok  = rd_en && !rd_empty;
    fr_inc = wr_ok && wr_eop;
    fr_dec = rd_ok && rd_unit[RD_DATA_WIDTH];
  end
  always_ff @(posedge clk)
    if (wr_ok)
      for (int i = 0; i < RATIO; i++)
        if ((LR+1)'(i) < n)
          mem[wptr[DEPTH_WIDTH-1:0] + DEPTH_WIDTH'(i)] <=
            {wr_eop && (LR+1)'(i) == n - 1'b1,
             wr_data[(MSB_FIRST ? RATIO-1-i : i)*RD_DATA_WIDTH +: RD_DATA_WIDTH]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr         <= '0;
      cptr         <= '0;
      rptr         <= '0;
      drop_pend    <= 1'b0;
      rd_data      <= '0;
      rd_eop       <= 1'b0;
      rd_frames    <= '0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      wr_overflow  <= ovf;
      rd_underflow <= rd_en && rd_empty;
      wptr         <= rewind ? cptr : wr_ok ? wptr_n : wptr;
      cptr         <= commit ? wptr_n : cptr;
      drop_pend    <= rewind ? 1'b0 : (PKT_MODE && ovf) ? 1'b1 : drop_pend;
      if (rd_ok) begin
        rptr    <= rptr + 1'b1;
        rd_data <= rd_unit[RD_DATA_WIDTH-1:0];
        rd_eop  <= rd_unit[RD_DATA_WIDTH];
      end
      if (fr_inc && !fr_dec && rd_frames != '1)
        rd_frames <= rd_frames + 1'b1;
      else if (fr_dec && !fr_inc && rd_frames != '0)
        rd_frames <= rd_frames - 1'b1;
    end
endmodule

// File: tb/tb_sig_pkt_width_fifo.sv
// tb_sig_pkt_width_fifo: scoreboard bench for the width-converting packet FIFO
module tb_sig_pkt_width_fifo;
  logic        clk = 0, rst_n = 0;
  logic        wr_en = 0, wr_eop = 0, wr_abort = 0, rd_en = 0;
  logic [31:0] wr_data = 0;
  logic [2:0]  wr_eop_units = 0;
  logic        wr_full, almost_full, wr_overflow, rd_eop, rd_empty, almost_empty, rd_underflow;
  logic [12:0] wr_water_level, rd_water_level;
  logic [7:0]  rd_data, rd_frames;
  int total = 0, bad = 0;
  logic [8:0] sb[$], pend[$];
  int m_used = 0, m_frames = 0;
  bit m_drop = 0;

  sig_pkt_width_fifo dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_eop(wr_eop),
    .wr_eop_units(wr_eop_units), .wr_abort(wr_abort), .wr_full(wr_full),
    .almost_full(almost_full), .wr_water_level(wr_water_level), .wr_overflow(wr_overflow),
    .rd_en(rd_en), .rd_data(rd_data), .rd_eop(rd_eop), .rd_empty(rd_empty),
    .almost_empty(almost_empty), .rd_water_level(rd_water_level), .rd_frames(rd_frames),
    .rd_underflow(rd_underflow));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit w, input logic [31:0] d, input bit e, input logic [2:0] u,
                      input bit ab, input bit r);
    bit full_pre, empty_pre;
    logic [8:0] x;
    int n;
    full_pre  = m_used > 4092;
    empty_pre = sb.size() == 0;
    wr_en = w; wr_data = d; wr_eop = e; wr_eop_units = u; wr_abort = ab; rd_en = r;
    tick;
    wr_en = 0; wr_eop = 0; wr_abort = 0; rd_en = 0;
    if (r && !empty_pre) begin
      x = sb.pop_front();
      m_used--;
      if (x[8]) m_frames--;
      total++;
      if ({rd_eop, rd_data} !== x)
        $display("FAIL rd_unit got eop=%0b data=%02h want eop=%0b data=%02h", rd_eop, rd_data, x[8], x[7:0]);
      if ({rd_eop, rd_data} !== x) bad++;
    end
    total++;
    if (rd_underflow !== (r && empty_pre)) begin
      bad++; $display("FAIL rd_underflow got %0b want %0b", rd_underflow, r && empty_pre);
    end
    total++;
    if (wr_overflow !== (w && full_pre && !ab)) begin
      bad++; $display("FAIL wr_overflow got %0b want %0b", wr_overflow, w && full_pre && !ab);
    end
    if (ab) begin
      m_used -= pend.size(); pend.delete(); m_drop = 0;
    end else if (w) begin
      if (m_drop || full_pre) begin
        if (e) begin m_used -= pend.size(); pend.delete(); m_drop = 0; end
        else m_drop = 1;
      end else begin
        n = (e && u != 0) ? int'(u) : 4;
        for (int i = 0; i < n; i++) pend.push_back({e && i == n-1, d[31-8*i -: 8]});
        m_used += n;
        if (e) begin
          foreach (pend[i]) sb.push_back(pend[i]);
          pend.delete();
          if (m_frames < 255) m_frames++;
        end
      end
    end
    total++;
    if (rd_frames !== 8'(m_frames)) begin
      bad++; $display("FAIL rd_frames got %0d want %0d", rd_frames, m_frames);
    end
    total++;
    if (wr_water_level !== 13'(m_used)) begin
      bad++; $display("FAIL wr_water_level got %0d want %0d", wr_water_level, m_used);
    end
    total++;
    if (rd_water_level !== 13'(sb.size())) begin
      bad++; $display("FAIL rd_water_level got %0d want %0d", rd_water_level, sb.size());
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 5000 && sb.size() > 0; i++) step(0, 0, 0, 0, 0, 1);
    total++;
    if (rd_empty !== 1'b1 || sb.size() != 0) begin
      bad++; $display("FAIL drain rd_empty got %0b want 1 (left %0d)", rd_empty, sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if ({rd_empty, almost_empty, wr_full, almost_full, wr_overflow, rd_underflow, rd_eop} !== 7'b1100000
        || wr_water_level !== 0 || rd_water_level !== 0 || rd_data !== 0 || rd_frames !== 0) begin
      bad++;
      $display("FAIL %s flags=%b wl=%0d rl=%0d data=%02h frames=%0d want flags=1100000 zeros", tag,
               {rd_empty, almost_empty, wr_full, almost_full, wr_overflow, rd_underflow, rd_eop},
               wr_water_level, rd_water_level, rd_data, rd_frames);
    end
  endtask

  task automatic test_reset;
    #1;
    check_reset_outputs("reset_state");
    tick; tick;
    rst_n = 1;
    tick;
    check_reset_outputs("after_release");
  endtask

  task automatic test_basic;
    step(1, 32'h11223344, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
    total++;
    if (rd_data !== 8'h44 || rd_eop !== 1'b1) begin
      bad++; $display("FAIL basic_last got %02h/%0b want 44/1", rd_data, rd_eop);
    end
  endtask

  task automatic test_commit;
    step(1, 32'h01020304, 0, 0, 0, 0);
    step(1, 32'h05060708, 0, 0, 0, 0);
    step(1, 32'h090a0b0c, 0, 0, 0, 0);
    total++;
    if (rd_empty !== 1'b1 || wr_water_level !== 13'd12) begin
      bad++; $display("FAIL uncommitted got empty=%0b wl=%0d want 1/12", rd_empty, wr_water_level);
    end
    step(1, 32'hAABBCCDD, 1, 2, 0, 0);
    total++;
    if (rd_water_level !== 13'd14 || rd_empty !== 1'b0) begin
      bad++; $display("FAIL committed got rl=%0d empty=%0b want 14/0", rd_water_level, rd_empty);
    end
    drain;
  endtask

  task automatic test_abort;
    step(1, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 32'hCAFEF00D, 0, 0, 0, 0);
    step(1, 32'h55555555, 1, 4, 1, 0);
    total++;
    if (wr_water_level !== 0 || rd_empty !== 1'b1) begin
      bad++; $display("FAIL abort got wl=%0d empty=%0b want 0/1", wr_water_level, rd_empty);
    end
    step(1, 32'h0A0B0C0D, 1, 3, 0, 0);
    drain;
  endtask

  task automatic test_overflow;
    step(1, 32'h76543210, 1, 0, 0, 0);
    for (int i = 0; i < 1023; i++) step(1, $urandom, 0, 0, 0, 0);
    total++;
    if (wr_full !== 1'b1 || almost_full !== 1'b1) begin
      bad++; $display("FAIL full got full=%0b af=%0b want 1/1", wr_full, almost_full);
    end
    step(1, 32'h12345678, 0, 0, 0, 0);
    step(1, 32'h9ABCDEF0, 0, 0, 0, 0);
    step(1, 32'h0F0F0F0F, 1, 4, 0, 0);
    total++;
    if (wr_water_level !== 13'd4 || wr_full !== 1'b0) begin
      bad++; $display("FAIL dropped got wl=%0d full=%0b want 4/0", wr_water_level, wr_full);
    end
    drain;
  endtask

  task automatic test_wrap;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4400; i++) step(i % 4 == 0, $urandom, i % 16 == 12, 3'($urandom_range(0, 4)), 0, 1);
    drain;
  endtask

  task automatic test_midframe_reset;
    step(1, 32'h01234567, 1, 4, 0, 0);
    step(1, 32'h89ABCDEF, 0, 0, 0, 1);
    step(1, 32'h13579BDF, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check_reset_outputs("midframe_reset");
    sb.delete(); pend.delete(); m_used = 0; m_frames = 0; m_drop = 0;
    tick;
    rst_n = 1;
    step(1, 32'hF1E2D3C4, 1, 0, 0, 0);
    drain;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_commit;
    test_abort;
    test_overflow;
    test_wrap;
    test_midframe_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
